gerador_varredura_display: RTL
==============================

// Module: gerador_varredura_display
// PURPOSE
//   Timing source for the 4-digit multiplexed 7-seg scoreboard display. Divides the board
//   clock into the scan signals clock120hz/clock60hz (2-bit digit-scan count) and clock2segs
//   (scoreboard/timer alternation), which drive the downstream digit-select mux directly.
//   forcar_placar restarts a full scoreboard window, e.g. on a scoring event.
// PARAMETERS
//   DIV_SCAN    208333  clock cycles per scan step (50 MHz / 240 -> clock120hz square ~120 Hz)
//   MODE_STEPS  480     scan steps per display-mode window (2 s); multiple of 4, >= 4
// PORTS
//   clock          in   1  board clock; all logic on rising edge
//   reset          in   1  synchronous, active-high reset
//   forcar_placar  in   1  request scoreboard mode; level or pulse, any cycle
//   clock120hz     out  1  scan count bit 0
//   clock60hz      out  1  scan count bit 1
//   clock2segs     out  1  0 = scoreboard (placar), 1 = timer (cronometro)
//   tick_varredura out  1  one-cycle pulse on each scan step
// BEHAVIOUR
//   - All state is registered. Reset: div_cnt=0, scan=00, step_cnt=0, pend=0, clock2segs=0,
//     tick_varredura=0. Reset asserted mid-operation clears everything on the next edge
//     and overrides forcar_placar.
//   - div_cnt counts 0..DIV_SCAN-1. On the edge where div_cnt==DIV_SCAN-1:
//     div_cnt<=0, scan<=scan+1 (wraps 11->00), tick_varredura<=1.
//     On every other edge tick_varredura<=0. The first tick after reset is DIV_SCAN edges later.
//   - {clock60hz,clock120hz} = scan. Sequence 00,01,10,11,00,... with each value held
//     DIV_SCAN cycles.
//   - step_cnt counts 0..MODE_STEPS-1 and advances only on a scan step.
//     On a step with step_cnt==MODE_STEPS-1: step_cnt<=0 and clock2segs toggles.
//     Because MODE_STEPS%4==0, a mode change always coincides with scan becoming 00.
//   - pend latch: pend <= forcar_placar | (pend & ~aplica).
//     aplica = scan step with scan==11 (scan about to become 00) and pend==1.
//     On aplica: clock2segs<=0 and step_cnt<=0. This also applies if the display already
//     shows the scoreboard, so the window is extended to a full MODE_STEPS.
//   - Simultaneous natural wrap and aplica: aplica wins. clock2segs=0, step_cnt=0.
//   - forcar_placar held high re-arms pend every cycle. The display stays on the
//     scoreboard for as long as it is held.
//   - forcar_placar is sampled directly. It is assumed synchronous to clock and debounced upstream.
//   - Outputs change only on scan-step edges, so the downstream mux never sees a glitch
//     between steps.
// TESTING (bench params DIV_SCAN=3, MODE_STEPS=8)
//   1 Reset held 5 cycles, then released -> all outputs 0. First tick_varredura on the
//     3rd edge after release, with scan=01 on that edge.
//   2 Free run 30 cycles -> scan 00,01,10,11,00 (3 cycles each). clock2segs 0->1 on the 8th tick
//     (edge 24) with scan=00. Toggles back on the 16th tick.
//   3 forcar_placar 1-cycle pulse while clock2segs=1 and scan=01 -> no change until the step
//     with scan 11->00. There clock2segs=0. It then stays 0 for exactly 8 ticks.
//   4 forcar_placar pulse one cycle before the natural 0->1 wrap tick -> clock2segs stays 0
//     and step_cnt restarts at 0.
//   5 reset asserted for 1 cycle mid-window (scan=10, clock2segs=1, tick pending) -> next edge
//     gives all outputs 0, pend cleared, counting restarts as in test 1.
//   6 forcar_placar held high for 100 cycles -> clock2segs stays 0 throughout. After release
//     it goes to 1 exactly 8 ticks after the last aplica.

Source files
------------

// File: rtl/gerador_varredura_display.sv
// Scan timing source for the 4-digit multiplexed 7-segment scoreboard.
// Divides the board clock into a 2-bit digit-scan count and a
// scoreboard/timer alternation flag.
// forcar_placar restarts a full scoreboard window at the next scan-cycle boundary.
// There is no handshake on this block. forcar_placar is a plain synchronous
// request level that is sampled on every rising edge, and the outputs are
// free-running registered levels.
module gerador_varredura_display #(
    parameter int DIV_SCAN   = 208333,
    parameter int MODE_STEPS = 480
) (
    input  logic clock,
    input  logic reset,
    input  logic forcar_placar,
    output logic clock120hz,
    output logic clock60hz,
    output logic clock2segs,
    output logic tick_varredura
);

    localparam int DW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
    localparam int SW = (MODE_STEPS > 1) ? $clog2(MODE_STEPS) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV_SCAN - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(MODE_STEPS - 1);

    logic [DW-1:0] div_cnt;
    logic [1:0]    scan;
    logic [SW-1:0] step_cnt;
    logic          pend;
    logic          mode;
    logic          tick_q;

    logic          step;
    logic          aplica;

    // A scan step fires on the last cycle of each divider period. The pending
    // scoreboard request is applied only as scan wraps 11->00, so a mode change
    // never lands in the middle of a digit scan.
    always_comb begin
        step   = (div_cnt == DIV_LAST);
        aplica = step && (scan == 2'b11) && pend;
    end

    // Divider, scan count, mode window and pending-request latch
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt  <= '0;
            scan     <= 2'b00;
            step_cnt <= '0;
            pend     <= 1'b0;
            mode     <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= step;
            pend   <= forcar_placar | (pend & ~aplica);
            if (step) begin
                div_cnt <= '0;
                scan    <= scan + 2'd1;
                if (aplica) begin
                    // A forced restart wins over a natural wrap on the same step
                    step_cnt <= '0;
                    mode     <= 1'b0;
                end else if (step_cnt == STEP_LAST) begin
                    step_cnt <= '0;
                    mode     <= ~mode;
                end else begin
                    step_cnt <= step_cnt + SW'(1);
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Outputs are plain register taps. They cannot glitch between steps.
    always_comb begin
        clock120hz     = scan[0];
        clock60hz      = scan[1];
        clock2segs     = mode;
        tick_varredura = tick_q;
    end

endmodule
